// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: valid/ready command front-end for the 4-bit ALU with iterative multi-bit shifts
module alu_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_negative,
    output logic             rsp_zero,
    output logic             rsp_error
);
    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
    localparam logic [WIDTH:0] CMAX = WIDTH;
    localparam logic [WIDTH:0] ONE  = 1;
    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   cnt_q;
    logic             neg_q, zero_q, err_q;
    logic             is_shift, illegal;
    logic [WIDTH:0]   cnt_d;
    logic [WIDTH-1:0] logic_y, step_d;
    // decode the incoming command and the next single-bit shift step of the accumulator
    always_comb begin
        is_shift = req_opcode <= 4'd2;
        illegal  = req_opcode >= 4'd7;
        cnt_d    = ({1'b0, req_b} >= CMAX) ? CMAX : {1'b0, req_b};
        logic_y  = (req_opcode == 4'd3) ? ~req_a :
                   (req_opcode == 4'd4) ? (req_a & req_b) :
                   (req_opcode == 4'd5) ? (req_a | req_b) :
                   (req_opcode == 4'd6) ? (req_a ^ req_b) : '0;
        step_d   = (op_q == 4'd0) ? {acc_q[WIDTH-2:0], 1'b0} :
                   (op_q == 4'd1) ? {1'b0, acc_q[WIDTH-1:1]} :
                                    {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    end
    // command FSM; accumulator doubles as the result register so flags track rsp_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    op_q <= req_opcode;
                    if (is_shift) begin
                        acc_q   <= req_a;
                        cnt_q   <= cnt_d;
                        neg_q   <= req_a[WIDTH-1];
                        zero_q  <= req_a == '0;
                        err_q   <= 1'b0;
                        state_q <= (cnt_d == '0) ? RESP : SHIFT;
                    end else begin
                        acc_q   <= logic_y;
                        neg_q   <= logic_y[WIDTH-1];
                        zero_q  <= logic_y == '0;
                        err_q   <= illegal;
                        state_q <= RESP;
                    end
                end
                SHIFT: begin
                    acc_q  <= step_d;
                    cnt_q  <= cnt_q - ONE;
                    neg_q  <= step_d[WIDTH-1];
                    zero_q <= step_d == '0;
                    if (cnt_q == ONE) state_q <= RESP;
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_ready    = state_q == IDLE;
    assign rsp_valid    = state_q == RESP;
    assign rsp_y        = acc_q;
    assign rsp_negative = neg_q;
    assign rsp_zero     = zero_q;
    assign rsp_error    = err_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table plus backpressure and mid-shift reset sequences
module tb_alu_seq_ctrl;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       req_valid = 0, req_ready;
    logic [3:0] req_opcode = 0, req_a = 0, req_b = 0;
    logic       rsp_valid, rsp_ready = 1;
    logic [3:0] rsp_y;
    logic       rsp_negative, rsp_zero, rsp_error;
    int         total = 0, bad = 0;

    alu_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_negative(rsp_negative),
        .rsp_zero(rsp_zero), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op, a, b;
        int         lat;
        logic [3:0] y;
        logic       n, z, e;
    } vec_t;
    vec_t v[12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] y, input logic n, input logic z, input logic e);
        chk({nm, ".y"}, rsp_y, y);
        chk({nm, ".neg"}, rsp_negative, n);
        chk({nm, ".zero"}, rsp_zero, z);
        chk({nm, ".err"}, rsp_error, e);
    endtask

    // issue one command with rsp_ready high, measure latency, check result and handshake
    task automatic do_cmd(input string nm, input vec_t t);
        int n;
        @(negedge clk);
        req_valid = 1; req_opcode = t.op; req_a = t.a; req_b = t.b;
        chk({nm, ".req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0; req_opcode = ~t.op; req_a = ~t.a; req_b = 4'd0;
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, ".lat"}, n, t.lat);
        chk_out(nm, t.y, t.n, t.z, t.e);
        @(posedge clk); #1;
        chk({nm, ".done"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        v[0]  = '{4'd0, 4'b0001, 4'b0010, 3, 4'b0100, 0, 0, 0};
        v[1]  = '{4'd2, 4'b1001, 4'b0011, 4, 4'b1111, 1, 0, 0};
        v[2]  = '{4'd2, 4'b1001, 4'b1111, 5, 4'b1111, 1, 0, 0};
        v[3]  = '{4'd1, 4'b1000, 4'b0100, 5, 4'b0000, 0, 1, 0};
        v[4]  = '{4'd1, 4'b1010, 4'b0000, 1, 4'b1010, 1, 0, 0};
        v[5]  = '{4'd8, 4'b1010, 4'b0101, 1, 4'b0000, 0, 1, 1};
        v[6]  = '{4'd3, 4'b1000, 4'b0000, 1, 4'b0111, 0, 0, 0};
        v[7]  = '{4'd4, 4'b1100, 4'b1010, 1, 4'b1000, 1, 0, 0};
        v[8]  = '{4'd5, 4'b1010, 4'b0101, 1, 4'b1111, 1, 0, 0};
        v[9]  = '{4'd6, 4'b1100, 4'b0110, 1, 4'b1010, 1, 0, 0};
        v[10] = '{4'd0, 4'b0011, 4'b0100, 5, 4'b0000, 0, 1, 0};
        v[11] = '{4'd1, 4'b1011, 4'b0001, 2, 4'b0101, 0, 0, 0};

        #12;
        chk("reset.ready_valid", {req_ready, rsp_valid}, 2'b10);
        chk_out("reset", 4'b0000, 0, 0, 0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 12; i++) do_cmd($sformatf("vec%0d", i), v[i]);

        // backpressure: XOR result held stable, pending request not taken until after handshake
        @(negedge clk);
        rsp_ready = 0; req_valid = 1; req_opcode = 4'd6; req_a = 4'b1100; req_b = 4'b1100;
        @(posedge clk); #1;
        req_opcode = 4'd4; req_a = 4'b1111; req_b = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp.hold%0d.vr", i), {rsp_valid, req_ready}, 2'b10);
            chk_out($sformatf("bp.hold%0d", i), 4'b0000, 0, 1, 0);
        end
        @(negedge clk); rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp.handshake", {rsp_valid, req_ready}, 2'b01);
        @(posedge clk); #1;
        req_valid = 0;
        chk("bp.next_valid", rsp_valid, 1);
        chk_out("bp.next", 4'b1111, 1, 0, 0);
        @(posedge clk); #1;
        chk("bp.next_done", {rsp_valid, req_ready}, 2'b01);

        // reset after two shift cycles drops the command
        @(negedge clk);
        req_valid = 1; req_opcode = 4'd0; req_a = 4'b0001; req_b = 4'b0100;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk);
        @(posedge clk); #2;
        chk("rst.pre_y", rsp_y, 4'b0100);
        rst_n = 0; #1;
        chk("rst.ready_valid", {req_ready, rsp_valid}, 2'b10);
        chk_out("rst", 4'b0000, 0, 0, 0);
        req_valid = 1; req_opcode = 4'd5; req_a = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst.held%0d", i), {req_ready, rsp_valid, rsp_y}, 6'b100000);
        end
        @(negedge clk); req_valid = 0; rst_n = 1;
        @(posedge clk); #1;
        chk("rst.no_rsp", {req_ready, rsp_valid}, 2'b10);
        do_cmd("post_rst_or", '{4'd5, 4'b1010, 4'b0101, 1, 4'b1111, 1, 0, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
